mv_operand_loader: RTL and testbench
====================================

Name: mv_operand_loader

Overview:
- Upstream feeder for the matrix-times-vector combinational stage.
- Accepts a serial stream of DW-bit elements over a valid/ready handshake: M*N matrix elements row-major, then N vector elements.
- Packs them into the flat matrix and vector buses the multiplier consumes.
- Presents one complete operand set with its own valid/ready handshake.

Parameters:
- M, 4, matrix row count.
- N, 4, matrix column count and vector length.
- DW, 8, element width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  DW  element value.
- in_last  input  1  marks the final element of a frame (element index M*N+N-1).
- out_valid  output  1  matrix_out/vector_out hold a complete operand set.
- out_ready  input  1  downstream consumes the set this cycle.
- matrix_out  output  DW*N*M  element (r,c) at bits [DW*(r*N+c) +: DW]; row r occupies [DW*N*(r+1)-1 : DW*N*r].
- vector_out  output  DW*N  element c at bits [DW*c +: DW].
- frame_err  output  1  one-cycle pulse on in_last/count mismatch.

Behaviour:
- Reset is asynchronous, active-low (rst_n).
  - All state cleared asynchronously: idx=0, state=LOAD.
  - in_ready=1 after reset deasserts; out_valid=0, frame_err=0.
  - matrix_out=0, vector_out=0.
- Element counter idx: width $clog2(M*N+N), range 0..M*N+N-1.
- An element is accepted on a cycle where in_valid && in_ready.
- States:
  - LOAD:
    - in_ready=1, out_valid=0.
    - Accepted element with idx < M*N is written to matrix slot idx; otherwise to vector slot idx-M*N.
    - idx increments on each accepted element.
  - LOAD exit conditions:
    - idx==M*N+N-1 accepted with in_last=1: idx←0, go FULL.
    - idx==M*N+N-1 accepted with in_last=0: frame_err pulses the next cycle. Element is still stored and the frame completes; go FULL.
    - in_last=1 accepted with idx<M*N+N-1: frame_err pulses the next cycle. Element is discarded, idx←0, buffer contents are undefined-but-stale, stay in LOAD. The frame is dropped and no out_valid is raised.
  - FULL:
    - out_valid=1, in_ready=0.
    - Outputs stable until out_valid && out_ready.
    - That cycle: out_valid←0 and in_ready←1 next cycle; go LOAD.
- Latency: out_valid rises the cycle after the last element is accepted. Minimum one idle cycle between consecutive frames (base build).
- out_valid must not drop without out_ready. Data must not change while out_valid=1.
- in_valid while in_ready=0: ignored; no state change.
- Reset mid-frame discards partial data; idx returns to 0.
- Slot data registers are not cleared between frames; every slot is overwritten by a complete frame.

Optional Feature:
- Macro: MV_LOADER_DBUF_EN.
- Defined:
  - Adds a second operand bank (ping-pong).
  - While one bank is presented (out_valid=1), in_ready stays 1 and the next frame loads into the other bank.
  - in_ready drops only when the load bank completes while the presented bank is still unconsumed.
  - On handshake, the completed bank is presented the next cycle, so back-to-back frames run with zero gap.
  - The error rules apply per bank.
- Undefined: single bank exactly as in Behaviour.

Test Plan:
- Reset, M=N=4, DW=8: stream 20 elements of value 1..20, in_last on the 20th, out_ready=1.
  - out_valid=1 one cycle after the 20th accept.
  - matrix_out[7:0]=1, matrix_out[127:120]=16.
  - vector_out[7:0]=17, vector_out[31:24]=20.
  - Feeding the multiplier yields row0 = 1*17+2*18+3*19+4*20 = 190.
- Backpressure: complete frame, hold out_ready=0 for 10 cycles with in_valid=1.
  - in_ready=0 and outputs unchanged throughout.
  - No element accepted until the cycle after out_ready=1.
- Early in_last on the 7th element -> frame_err pulses one cycle, no out_valid. A following correct 20-element frame is presented normally.
- Missing in_last on the 20th element -> frame_err pulse and out_valid=1 with the data stored.
- rst_n low asynchronously after 9 elements -> outputs 0 immediately. A subsequent 20-element frame loads from slot 0.
- With MV_LOADER_DBUF_EN: two frames streamed continuously with out_ready=1.
  - Second out_valid period follows the first with no idle cycle.
  - in_ready never drops.

Source files
------------

// File: rtl/mv_operand_loader_if.sv
// Handshake and operand bus shared by mv_operand_loader and its upstream/downstream peers.
// slave  : the loader side (consumes the element stream, produces operand sets)
// master : the peer side (produces the element stream, consumes operand sets)
interface mv_operand_loader_if #(
   parameter int M  = 4,
   parameter int N  = 4,
   parameter int DW = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [DW*N*M-1:0]   matrix_out;
   logic [DW*N-1:0]     vector_out;
   logic                frame_err;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, matrix_out, vector_out, frame_err
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, matrix_out, vector_out, frame_err
   );
endinterface

// File: rtl/mv_operand_loader.sv
// mv_operand_loader: packs a serial element stream (M*N matrix elements row-major,
// then N vector elements) into the flat matrix/vector operand buses and presents
// each complete set with a valid/ready handshake.
// Optional macro MV_LOADER_DBUF_EN adds a second operand bank (ping-pong) so the
// next frame loads while the current one is presented; undefined = single bank.
module mv_operand_loader #(
   parameter int M  = 4,
   parameter int N  = 4,
   parameter int DW = 8
) (
   input logic                clk,
   input logic                rst_n,
   mv_operand_loader_if.slave bus
);

   localparam int TOT = M*N + N;
   localparam int IW  = $clog2(TOT);
   localparam logic [IW-1:0] LAST_IDX = IW'(TOT - 1);

`ifdef MV_LOADER_DBUF_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   // S_LOAD: accepting elements.  S_FULL: a completed set is waiting and no bank is free.
   typedef enum logic {S_LOAD, S_FULL} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_frame_err;
   logic [DW-1:0]   r_slot [NB][TOT];

   logic            w_acc;
   logic            w_last_slot;
   logic            w_early;
   logic            w_wr_en;
   logic            w_done;
   logic            w_hs;
   logic            w_wr_bank;
   logic            w_rd_bank;
   logic [DW*N*M-1:0] w_matrix;
   logic [DW*N-1:0]   w_vector;

`ifdef MV_LOADER_DBUF_EN
   logic            r_wr_bank;
   logic            r_rd_bank;
   assign w_wr_bank = r_wr_bank;
   assign w_rd_bank = r_rd_bank;
`else
   assign w_wr_bank = 1'b0;
   assign w_rd_bank = 1'b0;
`endif

   assign w_acc       = bus.in_valid && r_in_ready;
   assign w_last_slot = (r_idx == LAST_IDX);
   // in_last before the final slot drops the frame; that element is never stored
   assign w_early     = bus.in_last && !w_last_slot;
   assign w_wr_en     = w_acc && !w_early;
   // reaching the final slot completes the frame whether or not in_last was set
   assign w_done      = w_acc && w_last_slot;
   assign w_hs        = r_out_valid && bus.out_ready;

   for (genvar gb = 0; gb < NB; gb++) begin : g_bank
      for (genvar gi = 0; gi < TOT; gi++) begin : g_slot
         // capture the element addressed by idx into its slot of the load bank
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_slot[gb][gi] <= '0;
            end else if (w_wr_en && (w_wr_bank == 1'(gb)) && (r_idx == IW'(gi))) begin
               r_slot[gb][gi] <= bus.in_data;
            end
         end
      end
   end

   // present the slots of the currently selected bank on the flat operand buses
   always_comb begin
      w_matrix = '0;
      w_vector = '0;
      for (int b = 0; b < NB; b++) begin
         if (w_rd_bank == 1'(b)) begin
            for (int i = 0; i < M*N; i++) begin
               w_matrix[DW*i +: DW] = r_slot[b][i];
            end
            for (int i = 0; i < N; i++) begin
               w_vector[DW*i +: DW] = r_slot[b][M*N + i];
            end
         end
      end
   end

   assign bus.matrix_out = w_matrix;
   assign bus.vector_out = w_vector;
   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.frame_err  = r_frame_err;

   // element counter, framing checks and load/present control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_LOAD;
         r_idx       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef MV_LOADER_DBUF_EN
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         if (w_acc) begin
            if (w_last_slot) begin
               r_idx       <= '0;
               r_frame_err <= !bus.in_last;
            end else if (bus.in_last) begin
               r_idx       <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end

`ifdef MV_LOADER_DBUF_EN
         case (r_state)
            S_LOAD: begin
               if (w_done) begin
                  if (!r_out_valid || bus.out_ready) begin
                     // presented bank free (or leaving now): swap banks, zero gap
                     r_rd_bank   <= r_wr_bank;
                     r_wr_bank   <= ~r_wr_bank;
                     r_out_valid <= 1'b1;
                  end else begin
                     // both banks hold unconsumed sets: stall the input
                     r_state    <= S_FULL;
                     r_in_ready <= 1'b0;
                  end
               end else if (w_hs) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_FULL: begin
               if (bus.out_ready) begin
                  // out_valid stays high: the waiting bank is presented next cycle
                  r_rd_bank  <= r_wr_bank;
                  r_wr_bank  <= ~r_wr_bank;
                  r_state    <= S_LOAD;
                  r_in_ready <= 1'b1;
               end
            end
            default: r_state <= S_LOAD;
         endcase
`else
         case (r_state)
            S_LOAD: begin
               if (w_done) begin
                  r_state     <= S_FULL;
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            S_FULL: begin
               if (bus.out_ready) begin
                  r_state     <= S_LOAD;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= S_LOAD;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_mv_operand_loader.sv
// Self-checking bench for mv_operand_loader (both single-bank and MV_LOADER_DBUF_EN builds).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mv_operand_loader;

   localparam int M   = 4;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TOT = M*N + N;

   typedef logic [DW-1:0] frame_t [TOT];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mv_operand_loader_if #(.M(M), .N(N), .DW(DW)) bus ();

   mv_operand_loader #(.M(M), .N(N), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // reference packing: element (r,c) at DW*(r*N+c), vector element c after the matrix
   function automatic logic [DW*N*M-1:0] exp_matrix(input frame_t f);
      logic [DW*N*M-1:0] m;
      m = '0;
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            m[DW*(r*N+c) +: DW] = f[r*N + c];
      return m;
   endfunction

   function automatic logic [DW*N-1:0] exp_vector(input frame_t f);
      logic [DW*N-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++) v[DW*c +: DW] = f[M*N + c];
      return v;
   endfunction

   function automatic frame_t random_frame();
      frame_t f;
      for (int i = 0; i < TOT; i++) f[i] = DW'($urandom);
      return f;
   endfunction

   // offer one element and return on the falling edge after it has been accepted
   task automatic push(input logic [DW-1:0] d, input logic last);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         compared++; mismatched++;
         $display("FAIL push_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input frame_t f, input bit with_last, input int max_gap);
      for (int i = 0; i < TOT; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         push(f[i], with_last && (i == TOT - 1));
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      compared++; if (bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
      compared++; if (bus.matrix_out !== '0) begin mismatched++; $display("FAIL reset_matrix: got %h want 0", bus.matrix_out); end
      compared++; if (bus.vector_out !== '0) begin mismatched++; $display("FAIL reset_vector: got %h want 0", bus.vector_out); end
      rst_n = 1'b1;
      @(negedge clk);
      compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      $display("reset released: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
   endtask

   task automatic test_basic();
      frame_t f;
      int sum;
      for (int i = 0; i < TOT; i++) f[i] = DW'(i + 1);
      bus.out_ready = 1'b1;
      send_frame(f, 1'b1, 0);
      compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); end
      compared++; if (bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL basic_frame_err: got %b want 0", bus.frame_err); end
      compared++; if (bus.matrix_out[7:0] !== 8'd1) begin mismatched++; $display("FAIL basic_m00: got %0d want 1", bus.matrix_out[7:0]); end
      compared++; if (bus.matrix_out[127:120] !== 8'd16) begin mismatched++; $display("FAIL basic_m33: got %0d want 16", bus.matrix_out[127:120]); end
      compared++; if (bus.vector_out[7:0] !== 8'd17) begin mismatched++; $display("FAIL basic_v0: got %0d want 17", bus.vector_out[7:0]); end
      compared++; if (bus.vector_out[31:24] !== 8'd20) begin mismatched++; $display("FAIL basic_v3: got %0d want 20", bus.vector_out[31:24]); end
      compared++; if (bus.matrix_out !== exp_matrix(f)) begin mismatched++; $display("FAIL basic_matrix: got %h want %h", bus.matrix_out, exp_matrix(f)); end
      compared++; if (bus.vector_out !== exp_vector(f)) begin mismatched++; $display("FAIL basic_vector: got %h want %h", bus.vector_out, exp_vector(f)); end
      sum = 0;
      for (int c = 0; c < N; c++) sum += int'(bus.matrix_out[DW*c +: DW]) * int'(bus.vector_out[DW*c +: DW]);
      compared++; if (sum !== 190) begin mismatched++; $display("FAIL basic_row0_dot: got %0d want 190", sum); end
      $display("frame 1..20 presented: row0 dot=%0d", sum);
      @(negedge clk);
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_consumed: out_valid=%b want 0", bus.out_valid); end
      compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready_back: in_ready=%b want 1", bus.in_ready); end
   endtask

   task automatic test_random();
      frame_t f;
      int hold;
      for (int k = 0; k < 5; k++) begin
         f = random_frame();
         bus.out_ready = 1'b0;
         send_frame(f, 1'b1, 2);
         compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL rand%0d_out_valid: got %b want 1", k, bus.out_valid); end
         compared++; if (bus.matrix_out !== exp_matrix(f)) begin mismatched++; $display("FAIL rand%0d_matrix: got %h want %h", k, bus.matrix_out, exp_matrix(f)); end
         compared++; if (bus.vector_out !== exp_vector(f)) begin mismatched++; $display("FAIL rand%0d_vector: got %h want %h", k, bus.vector_out, exp_vector(f)); end
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            @(negedge clk);
            compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(f)) begin
               mismatched++; $display("FAIL rand%0d_hold: out_valid=%b matrix=%h want 1 / %h", k, bus.out_valid, bus.matrix_out, exp_matrix(f));
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rand%0d_consumed: out_valid=%b want 0", k, bus.out_valid); end
         $display("random frame %0d presented after %0d hold cycles: vector=%h", k, hold, exp_vector(f));
      end
   endtask

   task automatic test_backpressure();
      frame_t fa, fb;
      fa = random_frame();
      bus.out_ready = 1'b0;
      send_frame(fa, 1'b1, 0);
`ifdef MV_LOADER_DBUF_EN
      compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_dbuf_ready_first: in_ready=%b want 1", bus.in_ready); end
      fb = random_frame();
      send_frame(fb, 1'b1, 0);
`else
      fb = fa;
`endif
      for (int t = 0; t < 10; t++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'($urandom);
         bus.in_last  = 1'($urandom);
         compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %b want 0", t, bus.in_ready); end
         compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid[%0d]: got %b want 1", t, bus.out_valid); end
         compared++; if (bus.matrix_out !== exp_matrix(fa) || bus.vector_out !== exp_vector(fa)) begin
            mismatched++; $display("FAIL bp_data[%0d]: got %h/%h want %h/%h", t, bus.matrix_out, bus.vector_out, exp_matrix(fa), exp_vector(fa));
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
`ifdef MV_LOADER_DBUF_EN
      compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(fb)) begin
         mismatched++; $display("FAIL bp_dbuf_second: out_valid=%b matrix=%h want 1 / %h", bus.out_valid, bus.matrix_out, exp_matrix(fb));
      end
      @(negedge clk);
`endif
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
      compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      // the garbage offered during the stall must not have shifted the element counter
      fa = random_frame();
      send_frame(fa, 1'b1, 0);
      compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(fa) || bus.vector_out !== exp_vector(fa)) begin
         mismatched++; $display("FAIL bp_next_frame: out_valid=%b matrix=%h want 1 / %h", bus.out_valid, bus.matrix_out, exp_matrix(fa));
      end
      $display("backpressure: 10 stalled cycles, next frame presented");
      @(negedge clk);
   endtask

   task automatic test_early_last();
      frame_t f;
      f = random_frame();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(f[i], 1'b0);
      push(f[6], 1'b1);
      compared++; if (bus.frame_err !== 1'b1) begin mismatched++; $display("FAIL early_err_pulse: got %b want 1", bus.frame_err); end
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL early_no_valid: got %b want 0", bus.out_valid); end
      @(negedge clk);
      compared++; if (bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL early_err_one_cycle: got %b want 0", bus.frame_err); end
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL early_still_no_valid: got %b want 0", bus.out_valid); end
      f = random_frame();
      send_frame(f, 1'b1, 1);
      compared++; if (bus.out_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
         mismatched++; $display("FAIL early_recover_flags: out_valid=%b frame_err=%b want 1/0", bus.out_valid, bus.frame_err);
      end
      compared++; if (bus.matrix_out !== exp_matrix(f) || bus.vector_out !== exp_vector(f)) begin
         mismatched++; $display("FAIL early_recover_data: got %h/%h want %h/%h", bus.matrix_out, bus.vector_out, exp_matrix(f), exp_vector(f));
      end
      $display("early in_last on element 7: frame dropped, next frame presented");
      @(negedge clk);
   endtask

   task automatic test_missing_last();
      frame_t f;
      f = random_frame();
      bus.out_ready = 1'b1;
      send_frame(f, 1'b0, 1);
      compared++; if (bus.frame_err !== 1'b1) begin mismatched++; $display("FAIL missing_err_pulse: got %b want 1", bus.frame_err); end
      compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL missing_out_valid: got %b want 1", bus.out_valid); end
      compared++; if (bus.matrix_out !== exp_matrix(f) || bus.vector_out !== exp_vector(f)) begin
         mismatched++; $display("FAIL missing_data: got %h/%h want %h/%h", bus.matrix_out, bus.vector_out, exp_matrix(f), exp_vector(f));
      end
      @(negedge clk);
      compared++; if (bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL missing_err_one_cycle: got %b want 0", bus.frame_err); end
      $display("missing in_last: frame_err pulsed, data presented");
   endtask

   task automatic test_async_reset();
      frame_t f;
      f = random_frame();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) push(f[i], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      compared++; if (bus.matrix_out !== '0 || bus.vector_out !== '0) begin
         mismatched++; $display("FAIL areset_outputs: got %h/%h want 0/0", bus.matrix_out, bus.vector_out);
      end
      compared++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         mismatched++; $display("FAIL areset_flags: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      f = random_frame();
      send_frame(f, 1'b1, 0);
      compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(f) || bus.vector_out !== exp_vector(f)) begin
         mismatched++; $display("FAIL areset_reload: out_valid=%b got %h/%h want %h/%h", bus.out_valid, bus.matrix_out, bus.vector_out, exp_matrix(f), exp_vector(f));
      end
      $display("async reset after 9 elements: cleared, next frame loaded from slot 0");
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      frame_t fa, fb;
      int drops;
      fa = random_frame();
      fb = random_frame();
      bus.out_ready = 1'b1;
`ifdef MV_LOADER_DBUF_EN
      drops = 0;
      for (int k = 0; k < 2*TOT; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = (k < TOT) ? fa[k] : fb[k - TOT];
         bus.in_last  = (k == TOT - 1) || (k == 2*TOT - 1);
         if (bus.in_ready !== 1'b1) drops++;
         @(negedge clk);
         if (k == TOT - 1) begin
            compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(fa)) begin
               mismatched++; $display("FAIL b2b_first: out_valid=%b matrix=%h want 1 / %h", bus.out_valid, bus.matrix_out, exp_matrix(fa));
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      compared++; if (drops !== 0) begin mismatched++; $display("FAIL b2b_in_ready_drops: got %0d want 0", drops); end
      compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_after: got %b want 1", bus.in_ready); end
`else
      send_frame(fa, 1'b1, 0);
      compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(fa)) begin
         mismatched++; $display("FAIL b2b_first: out_valid=%b matrix=%h want 1 / %h", bus.out_valid, bus.matrix_out, exp_matrix(fa));
      end
      compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_cycle: in_ready=%b want 0", bus.in_ready); end
      send_frame(fb, 1'b1, 0);
`endif
      compared++; if (bus.out_valid !== 1'b1 || bus.matrix_out !== exp_matrix(fb) || bus.vector_out !== exp_vector(fb)) begin
         mismatched++; $display("FAIL b2b_second: out_valid=%b got %h/%h want %h/%h", bus.out_valid, bus.matrix_out, bus.vector_out, exp_matrix(fb), exp_vector(fb));
      end
      @(negedge clk);
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_consumed: got %b want 0", bus.out_valid); end
      $display("back-to-back: two frames streamed and presented");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
